// File: rtl/fetch_unit_if.sv
// Bundle of the redirect, instruction-memory and decode handshakes seen by fetch_unit.
// master is the fetch unit's view; slave is the surrounding environment's view.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one imem fetch outstanding at most,
// and hands returned words to decode through a one-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        discard, discard_n;
  logic        inst_valid, inst_valid_n;
  logic [31:0] inst_data, inst_data_n;
  logic [31:0] inst_pc, inst_pc_n;
  logic        req_fire;

  assign bus.imem_req_valid = (state == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_data      = inst_data;
  assign bus.inst_pc        = inst_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      fetch_pc   <= 32'h0;
      discard    <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= 32'h0;
      inst_pc    <= 32'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      fetch_pc   <= fetch_pc_n;
      discard    <= discard_n;
      inst_valid <= inst_valid_n;
      inst_data  <= inst_data_n;
      inst_pc    <= inst_pc_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    fetch_pc_n   = fetch_pc;
    discard_n    = discard;
    inst_valid_n = inst_valid;
    inst_data_n  = inst_data;
    inst_pc_n    = inst_pc;

    unique case (state)
      S_REQ: begin
        if (req_fire) begin
          fetch_pc_n = pc;
          pc_n       = pc + 32'd4;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            inst_valid_n = 1'b1;
            inst_data_n  = bus.imem_rsp_data;
            inst_pc_n    = fetch_pc;
            state_n      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_valid && bus.inst_ready) begin
          inst_valid_n = 1'b0;
          state_n      = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    // A redirect overrides everything above; a fetch already in flight must be marked stale.
    if (bus.redirect_valid) begin
      pc_n         = {bus.redirect_pc[31:2], 2'b00};
      inst_valid_n = 1'b0;
      inst_data_n  = inst_data;
      inst_pc_n    = inst_pc;
      unique case (state)
        S_REQ: begin
          if (req_fire) begin
            state_n   = S_WAIT;
            discard_n = 1'b1;
          end else begin
            state_n = S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_n   = S_REQ;
            discard_n = 1'b0;
          end else begin
            state_n   = S_WAIT;
            discard_n = 1'b1;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table followed by a randomized run against
// an in-order delivery model with a variable-latency imem.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rdpc;
    logic        rqr;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        chk_buf;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    bus.redirect_valid = v.rdv;
    bus.redirect_pc    = v.rdpc;
    bus.imem_req_ready = v.rqr;
    bus.imem_rsp_valid = v.rspv;
    bus.imem_rsp_data  = v.rspd;
    bus.inst_ready     = v.irdy;
  endtask

  task automatic addVec(input logic r, input logic rdv, input logic [31:0] rdpc, input logic rqr,
                        input logic rspv, input logic [31:0] rspd, input logic irdy,
                        input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                        input logic chk_buf, input logic [31:0] e_ipc, input logic [31:0] e_idata);
    vec_t v;
    v = '{r, rdv, rdpc, rqr, rspv, rspd, irdy, e_rv, e_addr, e_iv, chk_buf, e_ipc, e_idata};
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  initial begin
    logic        pending, rsp_driven, prev_hold, prev_valid;
    logic [31:0] pend_addr, prev_addr, req_expect, exp_pc;
    int          cnt, idle;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;
    tick();

    // rst rdv rdpc rqr rspv rspd irdy | req_v addr inst_v chk_buf ipc idata
    addVec(1,0,0,1,0,0,1,            0,0,0,1,0,0);
    addVec(0,0,0,1,0,0,1,            1,32'h100,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0000,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            0,0,1,1,32'h100,32'hC0DE0000);
    addVec(0,0,0,1,1,BAD,1,          1,32'h104,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0001,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            0,0,1,1,32'h104,32'hC0DE0001);
    addVec(0,0,0,1,0,0,1,            1,32'h108,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0002,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,0,            0,0,1,1,32'h108,32'hC0DE0002);
    addVec(0,0,0,1,0,0,0,            0,0,1,1,32'h108,32'hC0DE0002);
    addVec(0,0,0,1,1,BAD,0,          0,0,1,1,32'h108,32'hC0DE0002);
    addVec(0,0,0,1,0,0,0,            0,0,1,1,32'h108,32'hC0DE0002);
    addVec(0,0,0,1,0,0,0,            0,0,1,1,32'h108,32'hC0DE0002);
    addVec(0,0,0,1,0,0,1,            0,0,1,1,32'h108,32'hC0DE0002);
    addVec(0,0,0,1,0,0,1,            1,32'h10C,0,0,0,0);
    addVec(0,1,32'h2002,1,0,0,1,     0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            0,0,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0003,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            1,32'h2000,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0004,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            0,0,1,1,32'h2000,32'hC0DE0004);
    addVec(0,1,32'h40,0,0,0,1,       1,32'h2004,0,0,0,0);
    addVec(0,1,32'hFFFFFFFC,1,0,0,1, 1,32'h40,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0005,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            1,32'hFFFFFFFC,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0006,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,1,            0,0,1,1,32'hFFFFFFFC,32'hC0DE0006);
    addVec(0,0,0,1,0,0,1,            1,32'h0,0,0,0,0);
    addVec(0,0,0,1,1,32'hC0DE0007,1, 0,0,0,0,0,0);
    addVec(0,0,0,1,0,0,0,            0,0,1,1,32'h0,32'hC0DE0007);
    addVec(1,0,0,1,0,0,0,            0,0,1,1,32'h0,32'hC0DE0007);
    addVec(1,0,0,1,0,0,0,            0,0,0,1,32'h0,32'h0);
    addVec(0,0,0,0,0,0,0,            1,32'h100,0,1,32'h0,32'h0);
    addVec(0,0,0,0,0,0,0,            1,32'h100,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("row%0d req_valid", i), {31'b0, bus.imem_req_valid}, {31'b0, tbl[i].e_rv});
      if (tbl[i].e_rv)
        checkOutput($sformatf("row%0d req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
      checkOutput($sformatf("row%0d inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].chk_buf) begin
        checkOutput($sformatf("row%0d inst_pc", i), bus.inst_pc, tbl[i].e_ipc);
        checkOutput($sformatf("row%0d inst_data", i), bus.inst_data, tbl[i].e_idata);
      end
      tick();
    end

    // Randomized run: requests must walk the PC stream, deliveries must be in program order.
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    tick();
    tick();
    rst        = 1'b0;
    pending    = 1'b0;
    rsp_driven = 1'b0;
    prev_hold  = 1'b0;
    prev_addr  = 32'h0;
    req_expect = RST_PC;
    exp_pc     = RST_PC;
    cnt        = 0;
    idle       = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.redirect_valid = ($urandom_range(15) == 0);
      bus.redirect_pc    = ($urandom_range(7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(7)))
                                                    : 32'($urandom);
      bus.imem_req_ready = ($urandom_range(2) != 0);
      bus.inst_ready     = ($urandom_range(3) != 0);
      #1;

      if (prev_hold) begin
        checkOutput("rand req_valid stable", {31'b0, bus.imem_req_valid}, 32'd1);
        checkOutput("rand req_addr stable", bus.imem_req_addr, prev_addr);
      end

      if (bus.imem_req_valid && bus.imem_req_ready) begin
        checkOutput("rand req_addr", bus.imem_req_addr, req_expect);
        checkOutput("rand one outstanding", {31'b0, pending}, 32'd0);
        pending   = 1'b1;
        pend_addr = bus.imem_req_addr;
        cnt       = 1 + $urandom_range(2);
        req_expect = req_expect + 32'd4;
      end

      if (bus.inst_valid && bus.inst_ready) begin
        checkOutput("rand inst_pc", bus.inst_pc, exp_pc);
        checkOutput("rand inst_data", bus.inst_data, memWord(exp_pc));
        exp_pc = exp_pc + 32'd4;
        idle   = 0;
      end else begin
        idle++;
      end

      if (bus.redirect_valid) begin
        req_expect = {bus.redirect_pc[31:2], 2'b00};
        exp_pc     = {bus.redirect_pc[31:2], 2'b00};
      end

      prev_valid = bus.imem_req_valid;
      prev_hold  = prev_valid && !bus.imem_req_ready && !bus.redirect_valid;
      prev_addr  = bus.imem_req_addr;

      if (idle > 200) begin
        checkOutput("rand delivery timeout", 32'(idle), 32'd0);
        break;
      end

      tick();
      if (rsp_driven) begin
        pending    = 1'b0;
        rsp_driven = 1'b0;
      end
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = BAD;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = memWord(pend_addr);
          rsp_driven         = 1'b1;
        end
      end else if ($urandom_range(5) == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
